// File: rtl/dadda_mul_arbiter.sv
// Round-robin front end that shares one combinational Dadda multiplier between two
// requesters, with registered operands/product and a tagged valid/ready response.
module dadda_mul_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_p,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   rsp_p_q, rsp_p_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_id_q, rsp_id_d;
    logic                 last_grant_q, last_grant_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     ops_done_q, ops_done_d;
    logic                 grant0_s, grant1_s;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE -> MUL -> RESP sequence and all datapath registers.
    always_comb begin
        state_d      = state_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_p_d      = rsp_p_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        ops_done_d   = ops_done_q;
        case (state_q)
            IDLE: begin
                if (grant0_s) begin
                    mul_a_d      = req0_a;
                    mul_b_d      = req0_b;
                    rsp_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = MUL;
                end else if (grant1_s) begin
                    mul_a_d      = req1_a;
                    mul_b_d      = req1_b;
                    rsp_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = MUL;
                end else begin
                    state_d      = IDLE;
                end
            end
            MUL: begin
                rsp_p_d     = mul_p;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + CNT_W'(1);
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mul_a_q      <= {WIDTH{1'b0}};
            mul_b_q      <= {WIDTH{1'b0}};
            rsp_p_q      <= {(2*WIDTH){1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            ops_done_q   <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_p_q      <= rsp_p_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign rsp_p      = rsp_p_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = busy_q;
    assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Scoreboard bench: directed scenarios then random traffic; a negedge monitor predicts
// grants, latency, busy, counter and products from an abstract transaction model.
module tb_dadda_mul_arbiter;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1, rdy;
    logic [W-1:0]  a0, b0, a1, b1;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic          rsp_valid, rsp_id, busy;
    logic [2*W-1:0] rsp_p;
    logic [CW-1:0] ops_done;

    dadda_mul_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_a(a1), .req1_b(b1),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rdy), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .busy(busy), .ops_done(ops_done)
    );

    // Stand-in for the Dadda instance.
    assign mul_p = 32'(mul_a) * 32'(mul_b);

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus-owned state
    logic [31:0] pq0[$];
    logic [31:0] pq1[$];
    logic h0 = 1'b0, h1 = 1'b0;
    logic stall = 1'b0, rnd_mode = 1'b0;
    logic tmo_flag = 1'b0, end_flag = 1'b0;

    // Monitor-owned state
    logic [32:0]   sb[$];
    logic          out_m = 1'b0;
    logic          last_m = 1'b1;
    logic [CW-1:0] cnt_m = '0;
    logic          post_rst = 1'b0, tmo_seen = 1'b0, end_done = 1'b0;
    logic          e0, e1;
    int            cyc = 0;
    int            acc_cyc = -10;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: abstract model of one-at-a-time round-robin service
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            out_m  = 1'b0;
            last_m = 1'b1;
            cnt_m  = '0;
            post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                chk("rst_mul_a", 32'(mul_a), 32'd0);
                chk("rst_mul_b", 32'(mul_b), 32'd0);
                chk("rst_rsp_p", rsp_p, 32'd0);
                chk("rst_rsp_id", 32'(rsp_id), 32'd0);
                post_rst = 1'b0;
            end
            e0 = !out_m && v0 && (!v1 || last_m);
            e1 = !out_m && v1 && (!v0 || !last_m);
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            chk("busy", 32'(busy), 32'(out_m));
            chk("rsp_valid", 32'(rsp_valid), 32'(out_m && (cyc >= acc_cyc + 2)));
            chk("ops_done", 32'(ops_done), 32'(cnt_m));
            if (rsp_valid && sb.size() > 0) begin
                chk("rsp_id", 32'(rsp_id), 32'(sb[0][32]));
                chk("rsp_p", rsp_p, sb[0][31:0]);
            end
            if (rsp_valid && rdy && out_m) begin
                void'(sb.pop_front());
                out_m = 1'b0;
                cnt_m = cnt_m + CW'(1);
            end
            if (v0 && req0_ready) begin
                sb.push_back({1'b0, 32'(a0) * 32'(b0)});
                out_m = 1'b1; acc_cyc = cyc; last_m = 1'b0;
            end else if (v1 && req1_ready) begin
                sb.push_back({1'b1, 32'(a1) * 32'(b1)});
                out_m = 1'b1; acc_cyc = cyc; last_m = 1'b1;
            end
            if (tmo_flag && !tmo_seen) begin
                tmo_seen = 1'b1;
                chk("watchdog_expired", 32'(tmo_flag), 32'd0);
            end
            if (end_flag && !end_done) begin
                end_done = 1'b1;
                chk("scoreboard_drained", 32'(sb.size()), 32'd0);
            end
        end
    end

    task automatic drive();
        v0 = (pq0.size() > 0) && (!rnd_mode || ($urandom_range(0, 2) != 0));
        if (v0) begin a0 = pq0[0][31:16]; b0 = pq0[0][15:0]; end
        else begin a0 = 16'($urandom); b0 = 16'($urandom); end
        v1 = (pq1.size() > 0) && (!rnd_mode || ($urandom_range(0, 2) != 0));
        if (v1) begin a1 = pq1[0][31:16]; b1 = pq1[0][15:0]; end
        else begin a1 = 16'($urandom); b1 = 16'($urandom); end
        rdy = rnd_mode ? ($urandom_range(0, 3) != 0) : !stall;
    endtask

    task automatic step();
        @(negedge clk);
        h0 = v0 && req0_ready;
        h1 = v1 && req1_ready;
        @(posedge clk);
        #1;
        if (h0) void'(pq0.pop_front());
        if (h1) void'(pq1.pop_front());
        drive();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || busy || rsp_valid) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) tmo_flag = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 3))
            0: return 16'h0000;
            1: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        drive();
        do_reset();

        // 1: single op from requester 0
        pq0.push_back({16'd2, 16'd8});
        drive();
        wait_idle();

        // 2: tie straight out of reset, requester 0 first
        do_reset();
        pq0.push_back({16'd164, 16'd165});
        pq1.push_back({16'h00FF, 16'h00AA});
        drive();
        wait_idle();

        // 3: both held valid for four ops, alternating grants
        pq0.push_back({16'd7, 16'd300});
        pq0.push_back({16'd1000, 16'd65});
        pq1.push_back({16'd200, 16'd1250});
        pq1.push_back({16'd12, 16'd12});
        drive();
        wait_idle();

        // 4: full-scale product held through a 5-cycle consumer stall
        stall = 1'b1;
        pq0.push_back({16'hFFFF, 16'hFFFF});
        pq1.push_back({16'd3, 16'd5});
        drive();
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        if (n >= 20) tmo_flag = 1'b1;
        repeat (5) step();
        stall = 1'b0;
        drive();
        wait_idle();

        // 5: reset while the multiply is in flight, then a tie
        pq0.push_back({16'd7, 16'd9});
        drive();
        h0 = 1'b0;
        n = 0;
        while (!h0 && n < 20) begin step(); n++; end
        if (n >= 20) tmo_flag = 1'b1;
        pq0.push_back({16'd11, 16'd13});
        pq1.push_back({16'd17, 16'd19});
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle();

        // 6: zero operands, then random traffic that wraps the counter several times
        pq0.push_back({16'd0, 16'd25});
        pq1.push_back({16'd25, 16'd0});
        drive();
        wait_idle();

        rnd_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) pq0.push_back({rand_operand(), rand_operand()});
            if ($urandom_range(0, 3) == 0) pq1.push_back({rand_operand(), rand_operand()});
            step();
        end
        wait_idle();
        rnd_mode = 1'b0;
        drive();

        end_flag = 1'b1;
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
